game_flow_sequencer: RTL and testbench

//  Per-frame game sequencer. Drives top-level game state (IDLE/PLAYING/VICTORY/DEFEAT/ERROR), in-frame stage
//  (WAITING->DRAW->CALCVALUE->MOVE->COLLISION->CHECKING) and difficulty phase. Sits between VGA timing
//  (frame_tick) and the enemy/player/bullet datapath, which acks each stage with stage_done.

---
 rtl/game_flow_sequencer_pkg.sv | 40 ++++
 rtl/game_flow_sequencer_watchdog.sv | 37 +++
 rtl/game_flow_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_game_flow_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_sequencer_pkg.sv
// Shared encodings and default sizing for the game flow sequencer.
package game_flow_sequencer_pkg;

    typedef enum logic [2:0] {
        GAME_IDLE    = 3'd0,
        GAME_PLAYING = 3'd1,
        GAME_VICTORY = 3'd2,
        GAME_DEFEAT  = 3'd3,
        GAME_ERROR   = 3'd4
    } game_state_e;

    typedef enum logic [2:0] {
        ONPLAY_WAITING   = 3'd0,
        ONPLAY_DRAW      = 3'd1,
        ONPLAY_CALCVALUE = 3'd2,
        ONPLAY_MOVE      = 3'd3,
        ONPLAY_COLLISION = 3'd4,
        ONPLAY_CHECKING  = 3'd5
    } onplay_state_e;

    localparam logic [1:0] PHASE_1 = 2'd0;
    localparam logic [1:0] PHASE_2 = 2'd1;
    localparam logic [1:0] PHASE_3 = 2'd2;
    localparam logic [1:0] PHASE_4 = 2'd3;

    localparam int GAME_NUM_PHASES    = 4;
    localparam int GAME_MAX_PHASE_CNT = 124;
    localparam int GAME_MAX_ENEMY_ROW = 3;
    localparam int GAME_MAX_ENEMY_COL = 5;
    localparam int GAME_MAX_ENEMY     = GAME_MAX_ENEMY_ROW * GAME_MAX_ENEMY_COL;
    localparam int GAME_PLAYER_LIVES  = 3;
    localparam int GAME_STAGE_TIMEOUT = 1023;

    // Stages that wait on a datapath acknowledge.
    function automatic logic is_active_stage(input onplay_state_e s);
        return (s == ONPLAY_DRAW) || (s == ONPLAY_CALCVALUE) ||
               (s == ONPLAY_MOVE) || (s == ONPLAY_COLLISION);
    endfunction

endpackage

// File: rtl/game_flow_sequencer_watchdog.sv
// Stage watchdog: counts cycles a stage has waited for its acknowledge and
// flags the cycle on which the wait reaches TIMEOUT.
module stage_watchdog
    import game_flow_sequencer_pkg::*;
#(
    parameter int TIMEOUT = GAME_STAGE_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;

    // clear arrives on the first cycle of a stage, so it masks the stale count.
    always_comb begin
        cnt_eff = clear ? '0 : cnt_q;
        timeout = run && (cnt_eff == CNT_W'(TIMEOUT - 1));
        cnt_d   = cnt_eff;
        if (run && (cnt_eff != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_eff + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_flow_sequencer.sv
// Per-frame game sequencer: game state, in-frame stage and difficulty phase.
// Optional build macro STAGE_WATCHDOG_EN adds a per-stage timeout to ERROR.
module game_flow_sequencer
    import game_flow_sequencer_pkg::*;
#(
    parameter int NUM_PHASES    = GAME_NUM_PHASES,
    parameter int PHASE_W       = 2,
    parameter int MAX_PHASE_CNT = GAME_MAX_PHASE_CNT,
    parameter int MAX_ENEMY     = GAME_MAX_ENEMY,
    parameter int ENEMY_CNT_W   = 4,
    parameter int PLAYER_LIVES  = GAME_PLAYER_LIVES,
    parameter int STAGE_TIMEOUT = GAME_STAGE_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   frame_tick,
    input  logic                   stage_done,
    input  logic [ENEMY_CNT_W-1:0] enemy_alive,
    input  logic                   player_hit,
    output logic [2:0]             game_state,
    output logic [2:0]             onplay_state,
    output logic                   stage_start,
    output logic [PHASE_W-1:0]     phase,
    output logic [2:0]             lives,
    output logic                   frame_overrun
);

    localparam int                 PCNT_W     = $clog2(MAX_PHASE_CNT + 1);
    localparam logic [PHASE_W-1:0] PHASE_TOP  = PHASE_W'(NUM_PHASES - 1);
    localparam logic [2:0]         LIVES_INIT = 3'(PLAYER_LIVES);

    game_state_e          game_q, game_d;
    onplay_state_e        onplay_q, onplay_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PCNT_W-1:0]    pcnt_q, pcnt_d;
    logic [2:0]           lives_q, lives_d;
    logic                 hit_q, hit_d;
    logic                 empty_q, empty_d;
    logic                 sstart_q, sstart_d;
    logic                 overrun_q, overrun_d;
    logic                 wd_timeout;
    logic                 unused_cfg;

    assign unused_cfg = ^{32'(MAX_ENEMY), 32'(STAGE_TIMEOUT)};

`ifdef STAGE_WATCHDOG_EN
    logic wd_run;

    assign wd_run = (game_q == GAME_PLAYING) && is_active_stage(onplay_q) && !stage_done;

    stage_watchdog #(
        .TIMEOUT(STAGE_TIMEOUT)
    ) u_stage_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (sstart_q),
        .run     (wd_run),
        .timeout (wd_timeout)
    );
`else
    assign wd_timeout = 1'b0;
`endif

    always_comb begin
        game_d    = game_q;
        onplay_d  = onplay_q;
        phase_d   = phase_q;
        pcnt_d    = pcnt_q;
        lives_d   = lives_q;
        hit_d     = hit_q;
        empty_d   = empty_q;
        sstart_d  = 1'b0;
        overrun_d = 1'b0;
        case (game_q)
            GAME_IDLE: begin
                if (start) begin
                    game_d   = GAME_PLAYING;
                    onplay_d = ONPLAY_WAITING;
                    lives_d  = LIVES_INIT;
                    phase_d  = PHASE_W'(PHASE_1);
                    pcnt_d   = '0;
                    hit_d    = 1'b0;
                end
            end
            GAME_PLAYING: begin
                // A tick outside WAITING is dropped, never queued.
                if (frame_tick && (onplay_q != ONPLAY_WAITING)) begin
                    overrun_d = 1'b1;
                end
                if (wd_timeout) begin
                    game_d   = GAME_ERROR;
                    onplay_d = ONPLAY_WAITING;
                end else begin
                    case (onplay_q)
                        ONPLAY_WAITING: begin
                            if (frame_tick) begin
                                onplay_d = ONPLAY_DRAW;
                                sstart_d = 1'b1;
                            end
                        end
                        ONPLAY_DRAW: begin
                            if (stage_done) begin
                                onplay_d = ONPLAY_CALCVALUE;
                                sstart_d = 1'b1;
                            end
                        end
                        ONPLAY_CALCVALUE: begin
                            if (stage_done) begin
                                onplay_d = ONPLAY_MOVE;
                                sstart_d = 1'b1;
                            end
                        end
                        ONPLAY_MOVE: begin
                            if (stage_done) begin
                                onplay_d = ONPLAY_COLLISION;
                                sstart_d = 1'b1;
                            end
                        end
                        ONPLAY_COLLISION: begin
                            if (player_hit) begin
                                hit_d = 1'b1;
                            end
                            if (stage_done) begin
                                onplay_d = ONPLAY_CHECKING;
                                empty_d  = (enemy_alive == '0);
                            end
                        end
                        ONPLAY_CHECKING: begin
                            onplay_d = ONPLAY_WAITING;
                            if (empty_q) begin
                                game_d = GAME_VICTORY;
                            end else if (hit_q && (lives_q <= 3'd1)) begin
                                lives_d = 3'd0;
                                game_d  = GAME_DEFEAT;
                            end else begin
                                if (hit_q) begin
                                    lives_d = lives_q - 3'd1;
                                end
                                hit_d = 1'b0;
                                if (pcnt_q == PCNT_W'(MAX_PHASE_CNT - 1)) begin
                                    pcnt_d = '0;
                                    if (phase_q != PHASE_TOP) begin
                                        phase_d = phase_q + PHASE_W'(1);
                                    end
                                end else begin
                                    pcnt_d = pcnt_q + PCNT_W'(1);
                                end
                            end
                        end
                        default: onplay_d = ONPLAY_WAITING;
                    endcase
                end
            end
            GAME_VICTORY, GAME_DEFEAT, GAME_ERROR: begin
                if (start) begin
                    game_d   = GAME_IDLE;
                    onplay_d = ONPLAY_WAITING;
                end
            end
            default: begin
                game_d   = GAME_IDLE;
                onplay_d = ONPLAY_WAITING;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_q    <= GAME_IDLE;
            onplay_q  <= ONPLAY_WAITING;
            phase_q   <= PHASE_W'(PHASE_1);
            pcnt_q    <= '0;
            lives_q   <= LIVES_INIT;
            hit_q     <= 1'b0;
            empty_q   <= 1'b0;
            sstart_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            game_q    <= game_d;
            onplay_q  <= onplay_d;
            phase_q   <= phase_d;
            pcnt_q    <= pcnt_d;
            lives_q   <= lives_d;
            hit_q     <= hit_d;
            empty_q   <= empty_d;
            sstart_q  <= sstart_d;
            overrun_q <= overrun_d;
        end
    end

    assign game_state    = game_q;
    assign onplay_state  = onplay_q;
    assign stage_start   = sstart_q;
    assign phase         = phase_q;
    assign lives         = lives_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Directed bench for game_flow_sequencer; watchdog scenario runs when STAGE_WATCHDOG_EN is defined.
module tb_game_flow_sequencer;
    import game_flow_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       stage_done = 1'b0;
    logic [3:0] enemy_alive = 4'd15;
    logic       player_hit = 1'b0;
    logic [2:0] game_state;
    logic [2:0] onplay_state;
    logic       stage_start;
    logic [1:0] phase;
    logic [2:0] lives;
    logic       frame_overrun;

    int checks = 0;
    int errors = 0;

    game_flow_sequencer #(.STAGE_TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .frame_tick    (frame_tick),
        .stage_done    (stage_done),
        .enemy_alive   (enemy_alive),
        .player_hit    (player_hit),
        .game_state    (game_state),
        .onplay_state  (onplay_state),
        .stage_start   (stage_start),
        .phase         (phase),
        .lives         (lives),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One whole frame from WAITING back to WAITING (or a terminal state).
    task automatic run_frame(input logic hit, input logic [3:0] alive, input bit stall);
        frame_tick = 1'b1;
        stage_done = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        tick();
        if (stall) begin
            stage_done = 1'b0;
            player_hit = hit;
            tick();
            player_hit = 1'b0;
            stage_done = 1'b1;
        end else begin
            player_hit = hit;
        end
        enemy_alive = alive;
        tick();
        player_hit  = 1'b0;
        stage_done  = 1'b0;
        enemy_alive = 4'd15;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (game_state !== GAME_IDLE) begin errors++; $display("FAIL reset_game act=%0d exp=%0d", game_state, GAME_IDLE); end
        checks++; if (onplay_state !== ONPLAY_WAITING) begin errors++; $display("FAIL reset_onplay act=%0d exp=%0d", onplay_state, ONPLAY_WAITING); end
        checks++; if (phase !== PHASE_1) begin errors++; $display("FAIL reset_phase act=%0d exp=%0d", phase, PHASE_1); end
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives act=%0d exp=3", lives); end
        checks++; if (stage_start !== 1'b0 || frame_overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses act=%b%b exp=00", stage_start, frame_overrun); end
        // frame_tick in IDLE is ignored
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks++; if (game_state !== GAME_IDLE || onplay_state !== ONPLAY_WAITING) begin errors++; $display("FAIL idle_ignores_tick act=%0d/%0d exp=0/0", game_state, onplay_state); end
    endtask

    task automatic test_first_frame();
        logic [2:0] exp_stage [4];
        exp_stage[0] = ONPLAY_DRAW;
        exp_stage[1] = ONPLAY_CALCVALUE;
        exp_stage[2] = ONPLAY_MOVE;
        exp_stage[3] = ONPLAY_COLLISION;
        pulse_start();
        checks++; if (game_state !== GAME_PLAYING || lives !== 3'd3) begin errors++; $display("FAIL start_play act=%0d lives=%0d exp=1 lives=3", game_state, lives); end
        stage_done = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (onplay_state !== ONPLAY_WAITING || stage_start !== 1'b0) begin errors++; $display("FAIL waiting_ignores_done act=%0d/%b exp=0/0", onplay_state, stage_start); end
        frame_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            frame_tick = 1'b0;
            checks++; if (onplay_state !== exp_stage[i] || stage_start !== 1'b1) begin errors++; $display("FAIL stage_%0d act=%0d/%b exp=%0d/1", i, onplay_state, stage_start, exp_stage[i]); end
        end
        tick();
        checks++; if (onplay_state !== ONPLAY_CHECKING || stage_start !== 1'b0) begin errors++; $display("FAIL checking act=%0d/%b exp=5/0", onplay_state, stage_start); end
        stage_done = 1'b0;
        tick();
        checks++; if (onplay_state !== ONPLAY_WAITING || game_state !== GAME_PLAYING || lives !== 3'd3 || phase !== PHASE_1) begin errors++; $display("FAIL frame_end act=%0d/%0d lives=%0d ph=%0d exp=0/1 lives=3 ph=0", onplay_state, game_state, lives, phase); end
        tick();
        checks++; if (onplay_state !== ONPLAY_WAITING || stage_start !== 1'b0) begin errors++; $display("FAIL idle_wait act=%0d/%b exp=0/0", onplay_state, stage_start); end
    endtask

    task automatic test_phase();
        for (int i = 0; i < 122; i++) run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (phase !== PHASE_1) begin errors++; $display("FAIL phase_f123 act=%0d exp=0", phase); end
        run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (phase !== PHASE_2) begin errors++; $display("FAIL phase_f124 act=%0d exp=1", phase); end
        for (int i = 0; i < 123; i++) run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (phase !== PHASE_2) begin errors++; $display("FAIL phase_f247 act=%0d exp=1", phase); end
        run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (phase !== PHASE_3) begin errors++; $display("FAIL phase_f248 act=%0d exp=2", phase); end
        for (int i = 0; i < 123; i++) run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (phase !== PHASE_3) begin errors++; $display("FAIL phase_f371 act=%0d exp=2", phase); end
        run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (phase !== PHASE_4) begin errors++; $display("FAIL phase_f372 act=%0d exp=3", phase); end
        for (int i = 0; i < 248; i++) run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (phase !== PHASE_4 || lives !== 3'd3 || game_state !== GAME_PLAYING) begin errors++; $display("FAIL phase_sat act=%0d lives=%0d gs=%0d exp=3 lives=3 gs=1", phase, lives, game_state); end
    endtask

    task automatic test_defeat();
        run_frame(1'b1, 4'd15, 1'b0);
        checks++; if (lives !== 3'd2 || game_state !== GAME_PLAYING) begin errors++; $display("FAIL hit1 act=lives %0d gs %0d exp=lives 2 gs 1", lives, game_state); end
        run_frame(1'b1, 4'd15, 1'b1);
        checks++; if (lives !== 3'd1 || game_state !== GAME_PLAYING) begin errors++; $display("FAIL hit2_sticky act=lives %0d gs %0d exp=lives 1 gs 1", lives, game_state); end
        run_frame(1'b0, 4'd15, 1'b0);
        checks++; if (lives !== 3'd1) begin errors++; $display("FAIL latch_cleared act=%0d exp=1", lives); end
        run_frame(1'b1, 4'd15, 1'b0);
        checks++; if (game_state !== GAME_DEFEAT || lives !== 3'd0 || onplay_state !== ONPLAY_WAITING) begin errors++; $display("FAIL defeat act=gs %0d lives %0d op %0d exp=gs 3 lives 0 op 0", game_state, lives, onplay_state); end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks++; if (game_state !== GAME_DEFEAT || onplay_state !== ONPLAY_WAITING || frame_overrun !== 1'b0) begin errors++; $display("FAIL defeat_frozen act=%0d/%0d/%b exp=3/0/0", game_state, onplay_state, frame_overrun); end
        pulse_start();
        checks++; if (game_state !== GAME_IDLE) begin errors++; $display("FAIL defeat_to_idle act=%0d exp=0", game_state); end
        pulse_start();
        checks++; if (game_state !== GAME_PLAYING || lives !== 3'd3 || phase !== PHASE_1) begin errors++; $display("FAIL replay act=gs %0d lives %0d ph %0d exp=gs 1 lives 3 ph 0", game_state, lives, phase); end
    endtask

    task automatic test_victory();
        run_frame(1'b1, 4'd15, 1'b0);
        run_frame(1'b1, 4'd15, 1'b0);
        checks++; if (lives !== 3'd1) begin errors++; $display("FAIL pre_victory_lives act=%0d exp=1", lives); end
        pulse_start();
        checks++; if (game_state !== GAME_PLAYING) begin errors++; $display("FAIL start_in_play act=%0d exp=1", game_state); end
        run_frame(1'b1, 4'd0, 1'b0);
        checks++; if (game_state !== GAME_VICTORY || lives !== 3'd1 || onplay_state !== ONPLAY_WAITING) begin errors++; $display("FAIL victory act=gs %0d lives %0d op %0d exp=gs 2 lives 1 op 0", game_state, lives, onplay_state); end
        pulse_start();
        checks++; if (game_state !== GAME_IDLE) begin errors++; $display("FAIL victory_to_idle act=%0d exp=0", game_state); end
        pulse_start();
        checks++; if (game_state !== GAME_PLAYING || lives !== 3'd3) begin errors++; $display("FAIL victory_replay act=gs %0d lives %0d exp=gs 1 lives 3", game_state, lives); end
    endtask

    task automatic test_overrun_and_reset();
        frame_tick = 1'b1;
        stage_done = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        stage_done = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks++; if (onplay_state !== ONPLAY_MOVE || frame_overrun !== 1'b1) begin errors++; $display("FAIL overrun_move act=%0d/%b exp=3/1", onplay_state, frame_overrun); end
        tick();
        checks++; if (frame_overrun !== 1'b0 || onplay_state !== ONPLAY_MOVE) begin errors++; $display("FAIL overrun_1cyc act=%b/%0d exp=0/3", frame_overrun, onplay_state); end
        stage_done = 1'b1;
        tick();
        tick();
        stage_done = 1'b0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks++; if (onplay_state !== ONPLAY_WAITING || frame_overrun !== 1'b1) begin errors++; $display("FAIL overrun_checking act=%0d/%b exp=0/1", onplay_state, frame_overrun); end
        tick();
        tick();
        checks++; if (onplay_state !== ONPLAY_WAITING || stage_start !== 1'b0) begin errors++; $display("FAIL no_queued_frame act=%0d/%b exp=0/0", onplay_state, stage_start); end
        run_frame(1'b1, 4'd15, 1'b0);
        frame_tick = 1'b1;
        stage_done = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        checks++; if (onplay_state !== ONPLAY_CALCVALUE || lives !== 3'd2) begin errors++; $display("FAIL pre_rst act=%0d lives %0d exp=2 lives 2", onplay_state, lives); end
        rst = 1'b1;
        frame_tick = 1'b1;
        tick();
        rst = 1'b0;
        frame_tick = 1'b0;
        stage_done = 1'b0;
        checks++; if (game_state !== GAME_IDLE || onplay_state !== ONPLAY_WAITING || lives !== 3'd3 || phase !== PHASE_1 || stage_start !== 1'b0 || frame_overrun !== 1'b0) begin errors++; $display("FAIL midframe_rst act=gs %0d op %0d lives %0d ph %0d ss %b ov %b exp=0 0 3 0 0 0", game_state, onplay_state, lives, phase, stage_start, frame_overrun); end
    endtask

`ifdef STAGE_WATCHDOG_EN
    task automatic test_watchdog();
        pulse_start();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (game_state !== GAME_PLAYING || onplay_state !== ONPLAY_DRAW) begin errors++; $display("FAIL wd_before act=%0d/%0d exp=1/1", game_state, onplay_state); end
        tick();
        checks++; if (game_state !== GAME_ERROR || onplay_state !== ONPLAY_WAITING) begin errors++; $display("FAIL wd_error act=%0d/%0d exp=4/0", game_state, onplay_state); end
        pulse_start();
        pulse_start();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;
        checks++; if (game_state !== GAME_PLAYING || onplay_state !== ONPLAY_CALCVALUE || stage_start !== 1'b1) begin errors++; $display("FAIL wd_done_wins act=%0d/%0d/%b exp=1/2/1", game_state, onplay_state, stage_start); end
        for (int i = 0; i < 7; i++) tick();
        checks++; if (game_state !== GAME_PLAYING || onplay_state !== ONPLAY_CALCVALUE) begin errors++; $display("FAIL wd_cleared act=%0d/%0d exp=1/2", game_state, onplay_state); end
        tick();
        checks++; if (game_state !== GAME_ERROR) begin errors++; $display("FAIL wd_error2 act=%0d exp=4", game_state); end
    endtask
`else
    task automatic test_no_watchdog();
        pulse_start();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks++; if (game_state !== GAME_PLAYING || onplay_state !== ONPLAY_DRAW) begin errors++; $display("FAIL wait_forever act=%0d/%0d exp=1/1", game_state, onplay_state); end
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;
        checks++; if (onplay_state !== ONPLAY_CALCVALUE || stage_start !== 1'b1) begin errors++; $display("FAIL late_done act=%0d/%b exp=2/1", onplay_state, stage_start); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_phase();
        test_defeat();
        test_victory();
        test_overrun_and_reset();
`ifdef STAGE_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
